// File: rtl/word_demux_bank.sv
// N-channel demultiplexing register bank: routes one write word into one of
// NUM_CH holding registers, addressed or round-robin, with per-channel valids.
module word_demux_bank #(
  parameter int WIDTH     = 32,
  parameter int NUM_CH    = 4,
  parameter int OVERWRITE = 1,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [SEL_W-1:0]        wr_sel,
  input  logic                    auto_mode,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       rd_ack,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [SEL_W-1:0]        wr_ptr,
  output logic                    full
);

  localparam int PAD_CH = 2 ** SEL_W;

  logic [WIDTH-1:0]  data_r [NUM_CH];
  logic [NUM_CH-1:0] valid_r;
  logic [SEL_W-1:0]  ptr_r;

  logic [PAD_CH-1:0] valid_pad_s;
  logic [SEL_W-1:0]  tgt_s;
  logic              sel_in_range_s;
  logic              ready_s;
  logic              accept_s;
  logic [NUM_CH-1:0] we_s;
  logic [NUM_CH-1:0] valid_nxt_s;
  logic [SEL_W-1:0]  ptr_nxt_s;

  // Round-robin successor that wraps at NUM_CH-1 for any channel count.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    if (int'(p) == NUM_CH - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + SEL_W'(1);
    end
  endfunction

  // Target selection, readiness and per-channel write enables.
  always_comb begin
    valid_pad_s    = PAD_CH'(valid_r);
    sel_in_range_s = (int'(wr_sel) < NUM_CH);
    tgt_s          = auto_mode ? ptr_r : wr_sel;
    ready_s        = 1'b0;
    if (clr) begin
      ready_s = 1'b0;
    end else if (auto_mode) begin
      ready_s = ~valid_pad_s[ptr_r];
    end else begin
      ready_s = sel_in_range_s & ((OVERWRITE != 0) | ~valid_pad_s[wr_sel]);
    end
    accept_s = wr_valid & ready_s;
    for (int i = 0; i < NUM_CH; i++) begin
      we_s[i] = accept_s && (int'(tgt_s) == i);
    end
  end

  // Next valid flags and pointer; clr outranks write, write outranks ack.
  always_comb begin
    valid_nxt_s = (valid_r & ~rd_ack) | we_s;
    ptr_nxt_s   = ptr_r;
    if (clr) begin
      valid_nxt_s = '0;
      ptr_nxt_s   = '0;
    end else if (accept_s && auto_mode) begin
      ptr_nxt_s = next_ptr(ptr_r);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r <= '0;
      ptr_r   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r <= valid_nxt_s;
      ptr_r   <= ptr_nxt_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (we_s[i]) begin
          data_r[i] <= wr_data;
        end else begin
          data_r[i] <= data_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = data_r[g];
  end

  assign out_valid = valid_r;
  assign wr_ptr    = ptr_r;
  assign full      = &valid_r;
  assign wr_ready  = ready_s;

endmodule

// File: tb/tb_word_demux_bank.sv
// Directed self-checking bench for word_demux_bank: default, non-overwrite
// and 3-channel/8-bit instances with hand-computed expectations.
module tb_word_demux_bank;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_valid;
  logic [31:0]  wr_data;
  logic [1:0]   wr_sel;
  logic         auto_mode;
  logic         clr;
  logic [3:0]   rd_ack;

  logic         ready_a, ready_b, full_a, full_b;
  logic [127:0] data_a, data_b;
  logic [3:0]   valid_a, valid_b;
  logic [1:0]   ptr_a, ptr_b;

  logic         c_wr_valid, c_auto, c_clr;
  logic [7:0]   c_wr_data;
  logic [1:0]   c_wr_sel;
  logic [2:0]   c_rd_ack;
  logic         ready_c, full_c;
  logic [23:0]  data_c;
  logic [2:0]   valid_c;
  logic [1:0]   ptr_c;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  always #5 clk = ~clk;

  word_demux_bank u_a (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_data(wr_data), .wr_sel(wr_sel), .auto_mode(auto_mode), .clr(clr),
    .rd_ack(rd_ack), .out_data(data_a), .out_valid(valid_a), .wr_ptr(ptr_a),
    .full(full_a)
  );

  word_demux_bank #(.OVERWRITE(0)) u_b (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(ready_b),
    .wr_data(wr_data), .wr_sel(wr_sel), .auto_mode(auto_mode), .clr(clr),
    .rd_ack(rd_ack), .out_data(data_b), .out_valid(valid_b), .wr_ptr(ptr_b),
    .full(full_b)
  );

  word_demux_bank #(.WIDTH(8), .NUM_CH(3)) u_c (
    .clk(clk), .reset_n(reset_n), .wr_valid(c_wr_valid), .wr_ready(ready_c),
    .wr_data(c_wr_data), .wr_sel(c_wr_sel), .auto_mode(c_auto), .clr(c_clr),
    .rd_ack(c_rd_ack), .out_data(data_c), .out_valid(valid_c), .wr_ptr(ptr_c),
    .full(full_c)
  );

  task automatic check_vec(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    wr_valid = 1'b0;
    rd_ack   = 4'b0000;
    clr      = 1'b0;
  endtask

  initial begin
    // Junk on every input while reset is held.
    reset_n = 1'b0; wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF; wr_sel = 2'd3;
    auto_mode = 1'b1; clr = 1'b1; rd_ack = 4'b1111;
    c_wr_valid = 1'b1; c_wr_data = 8'hEE; c_wr_sel = 2'd1; c_auto = 1'b1;
    c_clr = 1'b0; c_rd_ack = 3'b101;
    tick(); tick();
    reset_n = 1'b1; idle_a(); auto_mode = 1'b1;
    c_wr_valid = 1'b0; c_rd_ack = 3'b000;
    #1;
    check_vec("rst_data", 64'(data_a[63:0] | data_a[127:64]), 64'h0);
    check_vec("rst_valid", 64'(valid_a), 64'h0);
    check_vec("rst_ptr", 64'(ptr_a), 64'h0);
    check_vec("rst_full", 64'(full_a), 64'h0);
    check_vec("rst_ready", 64'(ready_a), 64'h1);
    check_vec("rst_c_data", 64'(data_c), 64'h0);

    // Addressed write, then overwrite accepted only when OVERWRITE=1.
    auto_mode = 1'b0; wr_sel = 2'd2; wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
    #1 check_vec("addr_ready", 64'(ready_a), 64'h1);
    tick();
    check_vec("addr_ch2", 64'(data_a[64 +: 32]), 64'hDEAD_BEEF);
    check_vec("addr_valid", 64'(valid_a), 64'h4);
    wr_data = 32'h0000_0001;
    #1 check_vec("ovw1_ready", 64'(ready_a), 64'h1);
    check_vec("ovw0_ready", 64'(ready_b), 64'h0);
    tick(); idle_a();
    check_vec("ovw1_ch2", 64'(data_a[64 +: 32]), 64'h1);
    check_vec("ovw0_ch2", 64'(data_b[64 +: 32]), 64'hDEAD_BEEF);
    check_vec("addr_ptr", 64'(ptr_a), 64'h0);
    rd_ack = 4'b0100;
    tick(); idle_a();
    check_vec("ack_valid", 64'(valid_a), 64'h0);
    check_vec("ack_keep", 64'(data_a[64 +: 32]), 64'h1);

    // Auto round-robin fill, back-pressure while full, refill of ch0.
    auto_mode = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA0 + 32'(i);
      tick();
    end
    check_vec("auto_data", 64'(data_a), 64'h0000_00A1_0000_00A0);
    check_vec("auto_data_hi", 64'(data_a[127:64]), 64'h0000_00A3_0000_00A2);
    check_vec("auto_full", 64'(full_a), 64'h1);
    check_vec("auto_ptr_wrap", 64'(ptr_a), 64'h0);
    wr_data = 32'hA4;
    #1 check_vec("auto_bp", 64'(ready_a), 64'h0);
    tick();
    check_vec("auto_blocked", 64'(data_a[31:0]), 64'hA0);
    rd_ack = 4'b0001;
    #1 check_vec("preack_ready", 64'(ready_a), 64'h0);
    tick(); rd_ack = 4'b0000;
    check_vec("auto_ack_valid", 64'(valid_a), 64'hE);
    check_vec("auto_notfull", 64'(full_a), 64'h0);
    tick(); idle_a();
    check_vec("auto_5th", 64'(data_a[31:0]), 64'hA4);
    check_vec("auto_ptr1", 64'(ptr_a), 64'h1);
    check_vec("auto_valid5", 64'(valid_a), 64'hF);

    // Write/ack collisions.
    rd_ack = 4'b1111; tick(); idle_a();
    auto_mode = 1'b0; wr_sel = 2'd1; wr_data = 32'h11; wr_valid = 1'b1;
    tick();
    wr_data = 32'h55; rd_ack = 4'b0010;
    tick();
    check_vec("coll_ch1", 64'(data_a[32 +: 32]), 64'h55);
    check_vec("coll_valid", 64'(valid_a), 64'h2);
    wr_sel = 2'd0; wr_data = 32'h77; rd_ack = 4'b1010;
    tick(); idle_a();
    check_vec("ackw_valid", 64'(valid_a), 64'h1);
    check_vec("ackw_ch0", 64'(data_a[31:0]), 64'h77);
    check_vec("ackw_ptr", 64'(ptr_a), 64'h1);

    // clr in the middle of an auto burst.
    rd_ack = 4'b1111; tick(); idle_a();
    auto_mode = 1'b1; wr_valid = 1'b1;
    wr_data = 32'hB0; tick();
    wr_data = 32'hB1; tick();
    check_vec("clr_pre_ptr", 64'(ptr_a), 64'h3);
    wr_data = 32'hCC; clr = 1'b1;
    #1 check_vec("clr_ready", 64'(ready_a), 64'h0);
    tick(); clr = 1'b0;
    check_vec("clr_valid", 64'(valid_a), 64'h0);
    check_vec("clr_ptr", 64'(ptr_a), 64'h0);
    check_vec("clr_keep", 64'(data_a[32 +: 64]), 64'h0000_00B1_0000_00B0);
    check_vec("clr_nowr", 64'(data_a[96 +: 32]), 64'hA3);
    wr_data = 32'hDD; tick(); idle_a();
    check_vec("post_clr_ch0", 64'(data_a[31:0]), 64'hDD);
    check_vec("post_clr_ptr", 64'(ptr_a), 64'h1);

    // Three-channel instance: wrap and out-of-range select.
    c_auto = 1'b1; c_wr_valid = 1'b1;
    c_wr_data = 8'h11; tick();
    c_wr_data = 8'h22; tick();
    check_vec("c_ptr2", 64'(ptr_c), 64'h2);
    c_wr_data = 8'h33; tick();
    check_vec("c_wrap", 64'(ptr_c), 64'h0);
    check_vec("c_full", 64'(full_c), 64'h1);
    c_wr_valid = 1'b0; c_rd_ack = 3'b111; tick(); c_rd_ack = 3'b000;
    c_wr_valid = 1'b1; c_wr_data = 8'h44; tick();
    c_auto = 1'b0; c_wr_sel = 2'd3; c_wr_data = 8'h99;
    #1 check_vec("c_sel3_ready", 64'(ready_c), 64'h0);
    tick(); c_wr_valid = 1'b0;
    check_vec("c_sel3_valid", 64'(valid_c), 64'h1);
    check_vec("c_sel3_data", 64'(data_c), 64'h33_2244);
    check_vec("c_sel3_ptr", 64'(ptr_c), 64'h1);

    // Reset mid-burst discards everything.
    wr_valid = 1'b1; auto_mode = 1'b1; reset_n = 1'b0; tick();
    reset_n = 1'b1; idle_a();
    check_vec("mrst_valid", 64'(valid_a), 64'h0);
    check_vec("mrst_ptr", 64'(ptr_a), 64'h0);
    check_vec("mrst_data", 64'(data_a[31:0]), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
